// File: rtl/dlx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dlx_pkg
// Purpose  : Shared DLX constants and fetch-stage types.
// Revision : 1.0  initial release
// ============================================================================
package dlx_pkg;

  localparam logic [31:0] c_nop_instr  = 32'h0000_0015;
  localparam logic [31:0] c_word_bytes = 32'd4;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
  } fetch_word_t;

endpackage
`default_nettype wire

// File: rtl/instr_fetch_if.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_if
// Purpose  : Memory, stall, branch-feedback and decoder signals of the fetch stage.
// Revision : 1.0  initial release
// ============================================================================
interface instr_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        br_valid;
  logic        br_beqz;
  logic        br_bnez;
  logic        br_jump;
  logic        br_jumpreg;
  logic [31:0] br_rs1_val;
  logic [15:0] br_imm16;
  logic [25:0] br_value;
  logic [31:0] br_pc_plus4;
  logic [31:0] instr;
  logic [31:0] pc_plus4;
  logic        instr_valid;

  modport master (
    output imem_req, imem_addr, instr, pc_plus4, instr_valid,
    input  imem_ack, imem_rdata, stall,
    input  br_valid, br_beqz, br_bnez, br_jump, br_jumpreg,
    input  br_rs1_val, br_imm16, br_value, br_pc_plus4
  );

  modport slave (
    input  imem_req, imem_addr, instr, pc_plus4, instr_valid,
    output imem_ack, imem_rdata, stall,
    output br_valid, br_beqz, br_bnez, br_jump, br_jumpreg,
    output br_rs1_val, br_imm16, br_value, br_pc_plus4
  );
endinterface
`default_nettype wire

// File: rtl/fetch_target.sv
`default_nettype none
// ============================================================================
// Module   : fetch_target
// Purpose  : Combinational branch/jump resolution: taken flag and target PC.
// Revision : 1.0  initial release
// ============================================================================
module fetch_target (
  input  logic        i_br_valid,
  input  logic        i_br_beqz,
  input  logic        i_br_bnez,
  input  logic        i_br_jump,
  input  logic        i_br_jumpreg,
  input  logic [31:0] i_rs1_val,
  input  logic [15:0] i_imm16,
  input  logic [25:0] i_value,
  input  logic [31:0] i_pc_plus4,
  output logic        o_taken,
  output logic [31:0] o_target
);

  logic        w_rs1_zero;
  logic [31:0] w_raw_target;

  always_comb begin
    w_rs1_zero = (i_rs1_val == 32'd0);
    o_taken    = i_br_valid &
                 (i_br_jump | (i_br_beqz & w_rs1_zero) | (i_br_bnez & ~w_rs1_zero));
    if (i_br_jumpreg) begin
      w_raw_target = i_rs1_val;
    end else if (i_br_jump) begin
      w_raw_target = i_pc_plus4 + {{6{i_value[25]}}, i_value};
    end else begin
      w_raw_target = i_pc_plus4 + {{16{i_imm16[15]}}, i_imm16};
    end
    o_target = {w_raw_target[31:2], 2'b00};
  end

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch
// Purpose  : DLX fetch stage with req/ack memory port, one-entry skid buffer
//            and branch redirect. Build option IFETCH_SQUASH_EN makes a
//            redirect insert a valid NOP bubble instead of clearing the output.
// Revision : 1.0  initial release
// ============================================================================
module instr_fetch
  import dlx_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  instr_fetch_if.master bus
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  fetch_addr_q, fetch_addr_d;
  logic         req_q, req_d;
  fetch_word_t  out_q, out_d;
  logic         out_valid_q, out_valid_d;
  fetch_word_t  skid_q, skid_d;
  logic         skid_valid_q, skid_valid_d;

  logic         w_taken;
  logic [31:0]  w_target;
  logic         w_ack;
  logic         w_to_skid;
  logic [31:0]  w_pc_inc;
  fetch_word_t  w_resp;

  fetch_target u_target (
    .i_br_valid   (bus.br_valid),
    .i_br_beqz    (bus.br_beqz),
    .i_br_bnez    (bus.br_bnez),
    .i_br_jump    (bus.br_jump),
    .i_br_jumpreg (bus.br_jumpreg),
    .i_rs1_val    (bus.br_rs1_val),
    .i_imm16      (bus.br_imm16),
    .i_value      (bus.br_value),
    .i_pc_plus4   (bus.br_pc_plus4),
    .o_taken      (w_taken),
    .o_target     (w_target)
  );

  assign w_ack     = req_q & bus.imem_ack;
  assign w_to_skid = out_valid_q & bus.stall;
  assign w_pc_inc  = pc_q + c_word_bytes;
  assign w_resp    = '{instr: bus.imem_rdata, pc_plus4: w_pc_inc};

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fetch_addr_d = fetch_addr_q;
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;

    if (out_valid_q && !bus.stall) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d  = 1'b0;
      end
    end

    unique case (state_q)
      FETCH_IDLE: begin
        if (!skid_valid_q) begin
          state_d      = FETCH_REQ;
          fetch_addr_d = pc_q;
        end
      end
      FETCH_REQ: begin
        if (w_ack) begin
          pc_d = w_pc_inc;
          // Skid is always empty in REQ, so a stalled full output parks the word there.
          if (w_to_skid) begin
            skid_d       = w_resp;
            skid_valid_d = 1'b1;
            state_d      = FETCH_IDLE;
          end else begin
            out_d        = w_resp;
            out_valid_d  = 1'b1;
            fetch_addr_d = w_pc_inc;
          end
        end
      end
      FETCH_DROP: begin
        if (w_ack) begin
          state_d = FETCH_IDLE;
        end
      end
      default: state_d = FETCH_IDLE;
    endcase

    if (w_taken) begin
      pc_d         = w_target;
      skid_valid_d = 1'b0;
`ifdef IFETCH_SQUASH_EN
      out_d        = '{instr: c_nop_instr, pc_plus4: w_target};
      out_valid_d  = 1'b1;
`else
      out_d        = out_q;
      out_valid_d  = 1'b0;
`endif
      // An issued request must complete at its original address before refetching.
      case (state_q)
        FETCH_IDLE: begin
          state_d      = FETCH_REQ;
          fetch_addr_d = w_target;
        end
        FETCH_REQ, FETCH_DROP: begin
          state_d      = w_ack ? FETCH_IDLE : FETCH_DROP;
          fetch_addr_d = fetch_addr_q;
        end
        default: state_d = FETCH_IDLE;
      endcase
    end

    req_d = (state_d != FETCH_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FETCH_IDLE;
      pc_q         <= RESET_PC;
      fetch_addr_q <= RESET_PC;
      req_q        <= 1'b0;
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fetch_addr_q <= fetch_addr_d;
      req_q        <= req_d;
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = fetch_addr_q;
  assign bus.instr       = out_q.instr;
  assign bus.pc_plus4    = out_q.pc_plus4;
  assign bus.instr_valid = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch
// Purpose  : Scoreboard bench for instr_fetch: stream model of expected words.
// Revision : 1.0  initial release
// ============================================================================
module tb_instr_fetch;

  typedef struct packed {
    logic        v, beqz, bnez, jump, jumpreg;
    logic [31:0] rs1;
    logic [15:0] imm;
    logic [25:0] val;
    logic [31:0] pc4;
  } br_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;

  localparam br_t NOBR = '0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   rst_cmd = 1'b1;
  always #5 clk = ~clk;

  instr_fetch_if bus ();
  instr_fetch_if bus2 ();

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (.clk(clk), .rst(rst), .bus(bus));
  instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (.clk(clk), .rst(rst), .bus(bus2));

  int          checks = 0;
  int          errors = 0;
  int          accepted = 0;
  exp_t        exp_q[$];
  logic [31:0] ptr = 32'h0;
  bit          drop_pend = 1'b0;
  bit          prev_req = 1'b0;
  bit          prev_ack = 1'b0;
  int          new_cnt = 0;
  logic [31:0] last_new_addr = 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_branch(input br_t b, output bit tk, output logic [31:0] tg);
    longint off;
    tk = b.v && (b.jump || (b.beqz && b.rs1 == 32'd0) || (b.bnez && b.rs1 != 32'd0));
    if (b.jumpreg) begin
      tg = b.rs1;
    end else begin
      if (b.jump) off = $signed(b.val);
      else        off = $signed(b.imm);
      tg = 32'(longint'(b.pc4) + off);
    end
    tg[1:0] = 2'b00;
  endfunction

  // End-of-cycle model update: runs after the monitor has seen this cycle's outputs.
  task automatic book(input br_t b);
    bit          req, ack, tk;
    logic [31:0] tg;
    if (rst) begin
      exp_q.delete();
      ptr = 32'h0; drop_pend = 1'b0; prev_req = 1'b0; prev_ack = 1'b0;
      return;
    end
    req = bus.imem_req;
    ack = req && bus.imem_ack;
    if (req && (!prev_req || prev_ack)) begin
      new_cnt++;
      last_new_addr = bus.imem_addr;
      chk32("fetch_addr", bus.imem_addr, ptr);
    end
    model_branch(b, tk, tg);
    if (tk) begin
      exp_q.delete();
      drop_pend = req && !ack;
      ptr = tg;
`ifdef IFETCH_SQUASH_EN
      exp_q.push_back('{instr: 32'h0000_0015, pc4: tg});
`endif
    end else if (ack) begin
      if (drop_pend) begin
        drop_pend = 1'b0;
      end else begin
        exp_q.push_back('{instr: mem_word(ptr), pc4: ptr + 32'd4});
        ptr = ptr + 32'd4;
      end
    end
    prev_req = req;
    prev_ack = ack;
  endtask

  task automatic cycle(input bit s, input bit a, input br_t b);
    @(posedge clk); #1;
    rst             = rst_cmd;
    bus.stall       = s;
    bus.imem_ack    = a;
    bus.imem_rdata  = mem_word(bus.imem_addr);
    bus.br_valid    = b.v;
    bus.br_beqz     = b.beqz;
    bus.br_bnez     = b.bnez;
    bus.br_jump     = b.jump;
    bus.br_jumpreg  = b.jumpreg;
    bus.br_rs1_val  = b.rs1;
    bus.br_imm16    = b.imm;
    bus.br_value    = b.val;
    bus.br_pc_plus4 = b.pc4;
    @(negedge clk); #1;
    book(b);
  endtask

  task automatic wait_new(output logic [31:0] a);
    int start;
    start = new_cnt;
    for (int i = 0; i < 40 && new_cnt == start; i++) cycle(1'b0, 1'b1, NOBR);
    if (new_cnt == start) begin
      checks++; errors++;
      $display("FAIL wait_new: no new request within 40 cycles");
    end
    a = last_new_addr;
  endtask

  // Monitor: pops one expected word per accepted instruction, checks request stability.
  initial begin : monitor
    exp_t        e;
    bit          m_req = 1'b0, m_ack = 1'b0;
    logic [31:0] m_addr = 32'h0;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_req = 1'b0; m_ack = 1'b0;
      end else begin
        if (bus.instr_valid && !bus.stall) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_instr: actual %h/%h expected none", bus.instr, bus.pc_plus4);
          end else begin
            e = exp_q.pop_front();
            chk32("instr", bus.instr, e.instr);
            chk32("pc_plus4", bus.pc_plus4, e.pc4);
            accepted++;
          end
        end
        if (bus.imem_req) begin
          chk32("addr_align", {30'd0, bus.imem_addr[1:0]}, 32'd0);
          if (m_req && !m_ack) chk32("addr_stable", bus.imem_addr, m_addr);
        end
        m_req = bus.imem_req; m_ack = bus.imem_ack; m_addr = bus.imem_addr;
      end
    end
  end

  initial begin : stim
    br_t         b;
    logic [31:0] a, ca;
    bus.stall = 0; bus.imem_ack = 0; bus.imem_rdata = 0;
    bus.br_valid = 0; bus.br_beqz = 0; bus.br_bnez = 0; bus.br_jump = 0; bus.br_jumpreg = 0;
    bus.br_rs1_val = 0; bus.br_imm16 = 0; bus.br_value = 0; bus.br_pc_plus4 = 0;
    bus2.stall = 0; bus2.imem_ack = 1; bus2.imem_rdata = 32'h1;
    bus2.br_valid = 0; bus2.br_beqz = 0; bus2.br_bnez = 0; bus2.br_jump = 0; bus2.br_jumpreg = 0;
    bus2.br_rs1_val = 0; bus2.br_imm16 = 0; bus2.br_value = 0; bus2.br_pc_plus4 = 0;

    rst_cmd = 1'b1;
    repeat (3) cycle(1'b0, 1'b0, NOBR);
    rst_cmd = 1'b0;

    // Reset state plus a stray ack that must be ignored.
    cycle(1'b0, 1'b1, NOBR);
    chk32("rst_req", {31'd0, bus.imem_req}, 32'd0);
    chk32("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
    chk32("rst_instr", bus.instr, 32'd0);
    chk32("rst_pc4", bus.pc_plus4, 32'd0);
    chk32("rst_addr", bus.imem_addr, 32'd0);
    chk32("wrap_rst_addr", bus2.imem_addr, 32'hFFFF_FFFC);
    cycle(1'b0, 1'b1, NOBR);
    chk32("first_req", {31'd0, bus.imem_req}, 32'd1);
    chk32("first_addr", bus.imem_addr, 32'h0);
    chk32("wrap_first_addr", bus2.imem_addr, 32'hFFFF_FFFC);
    cycle(1'b0, 1'b1, NOBR);
    chk32("first_valid", {31'd0, bus.instr_valid}, 32'd1);
    chk32("first_pc4", bus.pc_plus4, 32'h4);
    chk32("second_addr", bus.imem_addr, 32'h4);
    chk32("wrap_second_addr", bus2.imem_addr, 32'h0);
    chk32("wrap_pc4", bus2.pc_plus4, 32'h0);
    cycle(1'b0, 1'b1, NOBR);
    chk32("pc4_8", bus.pc_plus4, 32'h8);
    cycle(1'b0, 1'b1, NOBR);
    chk32("pc4_c", bus.pc_plus4, 32'hC);

    // Stall while acks keep arriving: one word parks in skid, request drops.
    cycle(1'b1, 1'b1, NOBR);
    cycle(1'b1, 1'b1, NOBR);
    chk32("skid_req_low", {31'd0, bus.imem_req}, 32'd0);
    cycle(1'b1, 1'b1, NOBR);
    repeat (6) cycle(1'b0, 1'b1, NOBR);

    // BEQZ taken with a request outstanding.
    wait_new(a);
    b = NOBR; b.v = 1; b.beqz = 1; b.rs1 = 32'h0; b.pc4 = 32'h100; b.imm = 16'hFFF0;
    cycle(1'b0, 1'b0, b);
    wait_new(a);
    chk32("beqz_target", a, 32'hF0);

    // BEQZ not taken.
    b.rs1 = 32'h5;
    cycle(1'b0, 1'b1, b);
    ca = bus.imem_addr;
    wait_new(a);
    chk32("beqz_not_taken", a, ca + 32'd4);

    // Register jump while outstanding; ack two cycles later is discarded.
    b = NOBR; b.v = 1; b.jump = 1; b.jumpreg = 1; b.rs1 = 32'h2003;
    cycle(1'b0, 1'b0, b);
    cycle(1'b0, 1'b0, NOBR);
    cycle(1'b0, 1'b1, NOBR);
    wait_new(a);
    chk32("jr_target", a, 32'h2000);

    // J with negative offset.
    b = NOBR; b.v = 1; b.jump = 1; b.val = 26'h3FF_FFFC; b.pc4 = 32'h8;
    cycle(1'b0, 1'b0, b);
    cycle(1'b0, 1'b0, NOBR);
`ifdef IFETCH_SQUASH_EN
    chk32("squash_valid", {31'd0, bus.instr_valid}, 32'd1);
    chk32("squash_instr", bus.instr, 32'h0000_0015);
    chk32("squash_pc4", bus.pc_plus4, 32'h4);
`else
    chk32("flush_valid", {31'd0, bus.instr_valid}, 32'd0);
`endif
    cycle(1'b0, 1'b1, NOBR);
    wait_new(a);
    chk32("j_target", a, 32'h4);

    // Reset while in DROP.
    b = NOBR; b.v = 1; b.jump = 1; b.jumpreg = 1; b.rs1 = 32'h40;
    cycle(1'b0, 1'b0, b);
    cycle(1'b0, 1'b0, NOBR);
    chk32("drop_req_held", {31'd0, bus.imem_req}, 32'd1);
    rst_cmd = 1'b1;
    cycle(1'b0, 1'b1, NOBR);
    rst_cmd = 1'b0;
    cycle(1'b0, 1'b1, NOBR);
    chk32("drop_rst_req", {31'd0, bus.imem_req}, 32'd0);
    chk32("drop_rst_valid", {31'd0, bus.instr_valid}, 32'd0);
    wait_new(a);
    chk32("post_rst_addr", a, 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      b = NOBR;
      if ($urandom_range(0, 99) < 8) begin
        b.v = 1;
        case ($urandom_range(0, 3))
          0: b.beqz = 1;
          1: b.bnez = 1;
          2: b.jump = 1;
          default: begin b.jump = 1; b.jumpreg = 1; end
        endcase
        b.rs1 = ($urandom_range(0, 1) == 0) ? 32'h0 : $urandom;
        b.imm = 16'($urandom);
        b.val = 26'($urandom);
        b.pc4 = $urandom;
      end
      rst_cmd = ($urandom_range(0, 999) == 0);
      cycle($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 60, b);
    end
    rst_cmd = 1'b0;

    checks++;
    if (accepted < 300) begin
      errors++;
      $display("FAIL progress: accepted %0d required at least 300", accepted);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
